// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_st full-adder cell is fed one bit pair per
// clock (LSB first), with the carry recirculated through a flop.

module fa_st (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic Cout
);
  assign sum  = a ^ b ^ c;
  assign Cout = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] sSr_q, sSr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic faSum;
  logic faCout;

  fa_st u_fa (
    .a    (aSr_q[0]),
    .b    (bSr_q[0]),
    .c    (carry_q),
    .sum  (faSum),
    .Cout (faCout)
  );

  always_comb begin
    state_d = state_q;
    aSr_d   = aSr_q;
    bSr_d   = bSr_q;
    sSr_d   = sSr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so results can stream back-to-back.
        if (start) begin
          aSr_d   = a_in;
          bSr_d   = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          sSr_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        aSr_d   = aSr_q >> 1;
        bSr_d   = bSr_q >> 1;
        sSr_d   = {faSum, sSr_q[WIDTH-1:1]};
        carry_d = faCout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {faSum, sSr_q[WIDTH-1:1]};
          cout_d  = faCout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      sSr_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      sSr_q   <= sSr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign Cout = cout_q;

endmodule
